// File: rtl/crank_cam_gen.sv
// crank_cam_gen: synthetic crank (missing-tooth wheel) and cam sensor generator.
// Each physical tooth occupies a slot of P clocks. The last physical tooth
// absorbs the missing slots and lasts (MISSING+1)*P clocks.
// vr is low for the first half of each slot and high for the second half.
// The optional per-tooth period ramp is enabled by defining CRANK_CAM_GEN_ACCEL_EN.
// When that macro is undefined, step and period_min have no effect.
module crank_cam_gen #(
  parameter int TEETH      = 60,
  parameter int MISSING    = 2,
  parameter int PW         = 16,
  parameter int TW         = 8,
  parameter int PERIOD_RST = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [PW-1:0] period_in,
  input  logic          period_ld,
  input  logic [PW-1:0] step,
  input  logic [PW-1:0] period_min,
  input  logic [TW-1:0] cam_start,
  input  logic [TW-1:0] cam_stop,
  output logic          vr,
  output logic          cam,
  output logic          phase,
  output logic [TW-1:0] tooth,
  output logic          gap,
  output logic          rev
);

  // Slot counter carries two extra bits so that (MISSING+1)*P never overflows.
  localparam int            CW         = PW + 2;
  localparam logic [TW-1:0] LAST_TOOTH = TW'(TEETH - MISSING - 1);
  localparam logic [PW-1:0] P_FLOOR    = PW'(4);
  localparam logic [PW-1:0] P_RESET    = PW'(PERIOD_RST);

  // Lower bound on any period that becomes active.
  function automatic logic [PW-1:0] clamp4(input logic [PW-1:0] p);
    return (p < P_FLOOR) ? P_FLOOR : p;
  endfunction

  // Slot length for a tooth: the extended tooth spans MISSING+1 periods.
  function automatic logic [CW-1:0] slot_len(input logic [PW-1:0] p, input logic ext);
    if (ext) begin
      return CW'(p) * CW'(MISSING + 1);
    end else begin
      return CW'(p);
    end
  endfunction

  logic [TW-1:0] tooth_r;
  logic [CW-1:0] cnt_r;
  logic [PW-1:0] per_r;
  logic [PW-1:0] shadow_r;
  logic          pend_r;
  logic          vr_r;
  logic          cam_r;
  logic          phase_r;
  logic          gap_r;
  logic          rev_r;

  logic [CW-1:0] len_s;
  logic          bnd_s;
  logic          wrap_s;
  logic [CW-1:0] cnt_nxt_s;
  logic [TW-1:0] tooth_nxt_s;
  logic          phase_nxt_s;
  logic [PW-1:0] ramp_s;
  logic [PW-1:0] per_nxt_s;
  logic [PW-1:0] shadow_nxt_s;
  logic          pend_nxt_s;
  logic [CW-1:0] len_nxt_s;
  logic          vr_nxt_s;
  logic          cam_nxt_s;
  logic          gap_nxt_s;
  logic          rev_nxt_s;

`ifdef CRANK_CAM_GEN_ACCEL_EN
  logic [PW-1:0] dec_s;

  // Period for the next tooth when no load is pending: subtract step, stop at the floor.
  always_comb begin
    if (per_r > step) begin
      dec_s = per_r - step;
    end else begin
      dec_s = {PW{1'b0}};
    end
    if (dec_s < period_min) begin
      ramp_s = clamp4(period_min);
    end else begin
      ramp_s = clamp4(dec_s);
    end
  end
`else
  logic unused_s;

  // Without the ramp the period only changes on an explicit load.
  always_comb begin
    ramp_s   = per_r;
    unused_s = ^{step, period_min};
  end
`endif

  // Next-state computation for counters, period pipeline and outputs.
  always_comb begin
    len_s  = slot_len(per_r, tooth_r == LAST_TOOTH);
    bnd_s  = (cnt_r == (len_s - CW'(1)));
    wrap_s = bnd_s && (tooth_r == LAST_TOOTH);

    if (bnd_s) begin
      cnt_nxt_s   = {CW{1'b0}};
      tooth_nxt_s = wrap_s ? {TW{1'b0}} : (tooth_r + TW'(1));
    end else begin
      cnt_nxt_s   = cnt_r + CW'(1);
      tooth_nxt_s = tooth_r;
    end

    phase_nxt_s = wrap_s ? ~phase_r : phase_r;

    // A pending load wins over the ramp at the boundary where it is applied.
    if (bnd_s && pend_r) begin
      per_nxt_s = clamp4(shadow_r);
    end else if (bnd_s) begin
      per_nxt_s = ramp_s;
    end else begin
      per_nxt_s = per_r;
    end

    // A load on the boundary cycle stays pending and applies one tooth later.
    if (period_ld) begin
      shadow_nxt_s = period_in;
      pend_nxt_s   = 1'b1;
    end else if (bnd_s) begin
      shadow_nxt_s = shadow_r;
      pend_nxt_s   = 1'b0;
    end else begin
      shadow_nxt_s = shadow_r;
      pend_nxt_s   = pend_r;
    end

    len_nxt_s = slot_len(per_nxt_s, tooth_nxt_s == LAST_TOOTH);
    vr_nxt_s  = (cnt_nxt_s >= {1'b0, len_nxt_s[CW-1:1]});
    cam_nxt_s = phase_nxt_s && (cam_start <= tooth_nxt_s) && (tooth_nxt_s < cam_stop);
    gap_nxt_s = (tooth_nxt_s == LAST_TOOTH);
    rev_nxt_s = wrap_s;
  end

  // Tooth/slot counters and period pipeline; all state holds while ena is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tooth_r  <= {TW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      per_r    <= P_RESET;
      shadow_r <= P_RESET;
      pend_r   <= 1'b0;
      phase_r  <= 1'b0;
    end else if (ena) begin
      tooth_r  <= tooth_nxt_s;
      cnt_r    <= cnt_nxt_s;
      per_r    <= per_nxt_s;
      shadow_r <= shadow_nxt_s;
      pend_r   <= pend_nxt_s;
      phase_r  <= phase_nxt_s;
    end else begin
      tooth_r  <= tooth_r;
      cnt_r    <= cnt_r;
      per_r    <= per_r;
      shadow_r <= shadow_r;
      pend_r   <= pend_r;
      phase_r  <= phase_r;
    end
  end

  // Registered sensor outputs, updated in step with the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vr_r  <= 1'b0;
      cam_r <= 1'b0;
      gap_r <= 1'b0;
      rev_r <= 1'b0;
    end else if (ena) begin
      vr_r  <= vr_nxt_s;
      cam_r <= cam_nxt_s;
      gap_r <= gap_nxt_s;
      rev_r <= rev_nxt_s;
    end else begin
      vr_r  <= vr_r;
      cam_r <= cam_r;
      gap_r <= gap_r;
      rev_r <= rev_r;
    end
  end

  assign vr    = vr_r;
  assign cam   = cam_r;
  assign phase = phase_r;
  assign tooth = tooth_r;
  assign gap   = gap_r;
  assign rev   = rev_r;

endmodule

// File: tb/tb_crank_cam_gen.sv
// Scoreboard bench for crank_cam_gen.
// A tooth-level reference model computes each tooth's length and levels from
// the wheel rules and pushes them into queues. A negedge monitor measures the
// DUT tooth by tooth and compares its measurements against those queues.
module tb_crank_cam_gen;

  localparam int NT    = 58;   // physical teeth per revolution
  localparam int LASTI = 57;   // extended tooth index
  localparam int MISS  = 2;
  localparam int PRST  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic [15:0] period_in = 16'd0;
  logic        period_ld = 1'b0;
  logic [15:0] step = 16'd0;
  logic [15:0] period_min = 16'd0;
  logic [7:0]  cam_start = 8'd4;
  logic [7:0]  cam_stop = 8'd54;
  logic        vr, cam, phase, gap, rev;
  logic [7:0]  tooth;

  crank_cam_gen dut (
    .clk(clk), .rst(rst), .ena(ena), .period_in(period_in), .period_ld(period_ld),
    .step(step), .period_min(period_min), .cam_start(cam_start), .cam_stop(cam_stop),
    .vr(vr), .cam(cam), .phase(phase), .tooth(tooth), .gap(gap), .rev(rev)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int len; int rev; int gap; int cam; int ph; } texp_t;
  texp_t exp_q[$];
  int    revlen_q[$];
  int    load_at[int];

  int total = 0;
  int bad   = 0;
  logic mon_on = 1'b0;
  logic ena_seen = 1'b1;

  always @(posedge clk) ena_seen <= ena;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int m_idx, m_i, m_rise, m_fall, m_chg, m_revcnt, m_revfirst, m_gap, m_cam, m_ph, m_prevvr;
  int rv_have, rv_len, rv_rises;
  int snap;
  logic m_on_prev = 1'b0;

  task automatic new_tooth();
    m_idx = tooth; m_i = 0; m_rise = -1; m_fall = 0; m_chg = 0;
    m_revcnt = 0; m_revfirst = rev; m_gap = gap; m_cam = cam; m_ph = phase; m_prevvr = 0;
  endtask

  task automatic sample();
    if (rev) begin
      if (rv_have != 0) begin
        if (revlen_q.size() == 0) chk("rev_extra", 1, 0);
        else chk("rev_period", rv_len, revlen_q.pop_front());
        chk("vr_rises_per_rev", rv_rises, NT);
      end
      rv_have = 1; rv_len = 0; rv_rises = 0;
    end
    rv_len++;
    if (vr && m_prevvr == 0) rv_rises++;
    if (vr && m_rise < 0) m_rise = m_i;
    if (!vr && m_prevvr != 0) m_fall++;
    m_prevvr = vr;
    if (gap != m_gap || cam != m_cam || phase != m_ph) m_chg++;
    if (rev) m_revcnt++;
    m_i++;
  endtask

  task automatic close_tooth();
    texp_t x;
    if (exp_q.size() == 0) begin
      chk("extra_tooth", m_idx, -1);
    end else begin
      x = exp_q.pop_front();
      chk("tooth_idx", m_idx, x.idx);
      chk("tooth_len", m_i, x.len);
      chk("vr_rise_at", m_rise, x.len / 2);
      chk("vr_fall_in_tooth", m_fall, 0);
      chk("rev_first", m_revfirst, x.rev);
      chk("rev_count", m_revcnt, x.rev);
      chk("gap", m_gap, x.gap);
      chk("cam", m_cam, x.cam);
      chk("phase", m_ph, x.ph);
      chk("level_stable", m_chg, 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && !m_on_prev) begin
        rv_have = 0; new_tooth(); sample();
      end else if (mon_on && !ena_seen) begin
        chk("freeze", {19'd0, vr, cam, phase, gap, rev, tooth}, snap);
      end else if (mon_on) begin
        if (tooth != m_idx) begin close_tooth(); new_tooth(); end
        sample();
      end
      m_on_prev = mon_on;
      snap = {19'd0, vr, cam, phase, gap, rev, tooth};
    end
  end

  task automatic chk_clear(input string tag);
    chk({tag, "_vr"}, vr, 0);
    chk({tag, "_cam"}, cam, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_tooth"}, tooth, 0);
    chk({tag, "_gap"}, gap, 0);
    chk({tag, "_rev"}, rev, 0);
  endtask

  // ---------------- model + driver ----------------
  task automatic run_seg(input int nt, input bit rnd, input int cs, input int ce,
                         input int ld0, input int stp, input int pmn,
                         input int fz_tooth, input int rst_tooth);
    int p, c, e, L, idx, r, val, revsum, rst_edge, fz_edge, end_edge;
    bit have;
    load_at.delete();
    rst_edge = -1; fz_edge = -1; revsum = 0;
    mon_on = 1'b0; rst = 1'b0; ena = 1'b1; period_ld = 1'b0;
    cam_start = cs[7:0]; cam_stop = ce[7:0];
`ifdef CRANK_CAM_GEN_ACCEL_EN
    step = stp[15:0]; period_min = pmn[15:0];
`else
    step = 16'($urandom); period_min = 16'($urandom);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_clear("reset");

    // Tooth-level model: a load seen anywhere in the window of tooth k
    // (whose first edge is the boundary ending tooth k-1) sets tooth k+1.
    p = PRST; c = 0;
    for (int k = 0; k < nt; k++) begin
      idx = k % NT; r = k / NT;
      L = (idx == LASTI) ? (MISS + 1) * p : p;
      if (k != rst_tooth)
        exp_q.push_back('{idx, L, (k > 0 && idx == 0) ? 1 : 0, (idx == LASTI) ? 1 : 0,
                          ((r % 2 == 1) && cs <= idx && idx < ce) ? 1 : 0, r % 2});
      revsum += L;
      if (idx == LASTI) begin
        if (r >= 1 && (rst_tooth < 0 || k < rst_tooth)) revlen_q.push_back(revsum);
        revsum = 0;
      end
      have = 1'b0; val = 0; e = 0;
      if (k == 0 && ld0 >= 0) begin
        val = ld0; e = c + 10; have = 1'b1;
      end else if (rnd && k == 3) begin
        val = 128; e = c + L / 2; have = 1'b1;            // mid-tooth load
      end else if (rnd && k == 6) begin
        val = 20; e = c; have = 1'b1;                     // load on the boundary cycle
      end else if (rnd && k == 9) begin
        val = 2; e = c + 1; have = 1'b1;                  // below the 4-clock floor
      end else if (rnd && k > 9 && $urandom_range(0, 2) == 0) begin
        val = $urandom_range(1, 100);
        e = ($urandom_range(0, 3) == 0) ? c : c + $urandom_range(1, L - 1);
        have = 1'b1;
      end
      if (have) load_at[e] = val;
      if (k == fz_tooth) fz_edge = c + L / 2;
      if (k == rst_tooth) rst_edge = c + 5;
      if (have) begin
        p = (val < 4) ? 4 : val;
      end
`ifdef CRANK_CAM_GEN_ACCEL_EN
      else begin
        p = (p > stp) ? p - stp : 0;
        if (p < pmn) p = pmn;
        if (p < 4) p = 4;
      end
`endif
      c += L;
    end
    end_edge = (rst_tooth >= 0) ? rst_edge : c;

    @(posedge clk);
    #1;
    rst = 1'b1; mon_on = 1'b1;
    for (int ed = 1; ed <= end_edge; ed++) begin
      if (ed == fz_edge) begin
        ena = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        ena = 1'b1;
      end
      if (ed == rst_edge) begin
        chk("pre_reset_tooth", tooth, rst_tooth % NT);
        chk("pre_reset_phase", phase, (rst_tooth / NT) % 2);
        mon_on = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_clear("async_reset");
        break;
      end
      period_ld = load_at.exists(ed) ? 1'b1 : 1'b0;
      period_in = load_at.exists(ed) ? 16'(load_at[ed]) : 16'($urandom);
      @(posedge clk);
      #1;
      period_ld = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("teeth_left", exp_q.size(), 0);
    chk("revs_left", revlen_q.size(), 0);
    exp_q.delete();
    revlen_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Defaults: P=64, cam window 4..53, two full revolutions.
    run_seg(2 * NT + 2, 1'b0, 4, 54, -1, 0, 0, -1, -1);
    // Loads (mid, boundary, sub-floor, random), random cam window, 500-clock freeze.
    run_seg(3 * NT, 1'b1, $urandom_range(0, 60), $urandom_range(0, 60), -1, 0, 0, 20, -1);
    // Inverted window keeps cam low.
    run_seg(2 * NT + 1, 1'b0, 54, 4, -1, 0, 0, -1, -1);
    // Asynchronous reset at tooth 30 of the phase=1 revolution, then defaults again.
    run_seg(NT + 31, 1'b0, 4, 54, -1, 0, 0, -1, NT + 30);
    run_seg(NT + 2, 1'b0, 4, 54, -1, 0, 0, -1, -1);
`ifdef CRANK_CAM_GEN_ACCEL_EN
    // Ramp from 200 down by 1 per tooth to a floor of 100.
    run_seg(120, 1'b0, 4, 54, 200, 1, 100, -1, -1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crank_cam_gen.md
CRANK_CAM_GEN -- requirements
Module: crank_cam_gen

Interface
REQ-001 SHALL have parameter TEETH, 60, tooth slots per crank revolution, including missing slots.
REQ-002 SHALL have parameter MISSING, 2, missing teeth (1..3), merged into the last physical tooth.
REQ-003 SHALL have parameter PW, 16, width of tooth-period values in clocks.
REQ-004 SHALL have parameter TW, 8, width of the tooth index.
REQ-005 SHALL have parameter PERIOD_RST, 64, active tooth period after reset.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ena, input, 1, run enable; low freezes all state.
REQ-009 SHALL have port period_in, input, PW, new tooth period in clocks.
REQ-010 SHALL have port period_ld, input, 1, one-cycle load strobe for period_in.
REQ-011 SHALL have port step, input, PW, per-tooth period decrement (acceleration).
REQ-012 SHALL have port period_min, input, PW, floor for the ramped period.
REQ-013 SHALL have ports cam_start and cam_stop, input, TW each, cam-high tooth window.
REQ-014 SHALL have port vr, output, 1, crank sensor pulse.
REQ-015 SHALL have port cam, output, 1, cam sensor level.
REQ-016 SHALL have port phase, output, 1, 720-degree half-cycle flag.
REQ-017 SHALL have port tooth, output, TW, current physical tooth index.
REQ-018 SHALL have ports gap, output, 1, high during the extended tooth, and rev, output, 1, one-cycle pulse on wrap to tooth 0.

Function
REQ-019 SHALL count physical teeth 0..TEETH-MISSING-1, then wrap to 0.
REQ-020 SHALL give each tooth a slot of L = P clocks, except tooth TEETH-MISSING-1, where L = (MISSING+1)*P; P = active period.
REQ-021 SHALL drive vr low for slot counts 0..L/2-1 (integer division) and high for counts L/2..L-1.
REQ-022 SHALL use a slot counter at least PW+2 bits wide; no overflow for any legal P and MISSING.
REQ-023 SHALL clamp the active period to a minimum of 4 clocks.
REQ-024 SHALL capture period_in into a shadow register on period_ld and apply it at the next tooth boundary; a load coinciding with a boundary takes effect on the following tooth.
REQ-025 SHALL hold gap high for the whole extended tooth.
REQ-026 SHALL pulse rev for exactly one clock at the first clock of tooth 0.
REQ-027 SHALL toggle phase at each wrap to tooth 0.
REQ-028 SHALL drive cam high when phase=1 and cam_start <= tooth < cam_stop, and low otherwise; cam_start >= cam_stop gives cam constantly low.
REQ-029 SHALL, with ena low, hold all counters and outputs; rev SHALL NOT repeat on resume.

Reset
REQ-030 SHALL, on rst low, asynchronously set tooth=0, slot count=0, vr=0, cam=0, phase=0, gap=0, rev=0, active and shadow period=PERIOD_RST, and clear any pending load.
REQ-031 SHALL, after rst release mid-revolution, restart from tooth 0, count 0, with no rev pulse until the first wrap.

Configuration
REQ-032 SHALL, with macro CRANK_CAM_GEN_ACCEL_EN defined, set P to max(P-step, period_min) at every tooth boundary with no pending load; a pending load overrides the ramp at that boundary.
REQ-033 SHALL, without CRANK_CAM_GEN_ACCEL_EN, keep P constant except on load, with step and period_min ignored.

Verification
REQ-034 SHALL verify defaults, P=64, ena=1: first vr rise 32 clocks after reset; tooth 57 lasts 192 clocks with vr rising at count 96; rev period 3840 clocks; 58 vr rises per revolution.
REQ-035 SHALL verify cam_start=4, cam_stop=54: cam high for teeth 4..53 only in revolutions with phase=1, and phase alternates every rev.
REQ-036 SHALL verify ACCEL_EN with P=200, step=1, period_min=100: tooth n lasts 200-n clocks until the floor, then 100 clocks.
REQ-037 SHALL verify period_ld=128 mid-tooth: the current tooth completes at 64 clocks and the next tooth lasts 128 clocks; a load on a boundary cycle applies one tooth later.
REQ-038 SHALL verify ena low for 500 clocks mid-tooth: all outputs frozen, and the tooth resumes with its remaining count.
REQ-039 SHALL verify rst asserted at tooth 30, phase=1: all outputs clear immediately; after release the sequence matches REQ-034.
